// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and GF(2^8) helpers for the
// iterative decryptor and its round-key expander.
package aes_pkg;

  localparam int unsigned NR = 10;

  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} state_e;

  // Entry 0 sits in the top byte of each table.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

endpackage

// File: rtl/decryption_seq_inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless last_i is set.
module inv_round (
  input  logic [127:0] st_i,
  input  logic [127:0] rk_i,
  input  logic         last_i,
  output logic [127:0] next_st_o
);
  import aes_pkg::*;

  logic [127:0] shifted;
  logic [127:0] keyed;
  logic [127:0] mixed;

  always_comb begin
    shifted = '0;
    keyed   = '0;
    // Byte i of the state is row i%4, column i/4; row r rotates right by r.
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        shifted[127 - 8*(4*c + r) -: 8] = st_i[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
      end
    end
    for (int unsigned i = 0; i < 16; i++) begin
      keyed[127 - 8*i -: 8] = inv_sbox(shifted[127 - 8*i -: 8]) ^ rk_i[127 - 8*i -: 8];
    end
  end

  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    mixed = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = keyed[127 - 32*c -: 8];
      a1 = keyed[119 - 32*c -: 8];
      a2 = keyed[111 - 32*c -: 8];
      a3 = keyed[103 - 32*c -: 8];
      mixed[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      mixed[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      mixed[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      mixed[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
  end

  assign next_st_o = last_i ? keyed : mixed;

endmodule

// File: rtl/round_key11.sv
// Combinational AES-128 key expander: rk_o[0] is the cipher key,
// rk_o[r] the round-r key.
module round_key11 #(
  parameter int unsigned NR = 10
) (
  input  logic [127:0]         key_i,
  output logic [NR:0][127:0]   rk_o
);
  import aes_pkg::*;

  always_comb begin
    logic [127:0] k;
    logic [31:0]  w0, w1, w2, w3, tmp;
    logic [7:0]   rcon;
    k       = key_i;
    rcon    = 8'h01;
    rk_o    = '0;
    rk_o[0] = k;
    for (int unsigned r = 1; r <= NR; r++) begin
      w0   = k[127:96];
      w1   = k[95:64];
      w2   = k[63:32];
      w3   = k[31:0];
      tmp  = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
      w0   = w0 ^ tmp;
      w1   = w1 ^ w0;
      w2   = w2 ^ w1;
      w3   = w3 ^ w2;
      k    = {w0, w1, w2, w3};
      rcon = xtime(rcon);
      rk_o[r] = k;
    end
  end

endmodule

// File: rtl/decryption_seq.sv
// Iterative AES-128 decryptor: one inverse round per clock over a shared
// datapath, valid/ready on both sides, one block in flight at a time.
module decryption_seq #(
  parameter int unsigned NR      = aes_pkg::NR,
  parameter bit          CLR_OUT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  import aes_pkg::*;

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [127:0] st_q, st_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] out_data_q, out_data_d;
  logic         out_valid_q, out_valid_d;

  logic [NR:0][127:0] rk;
  logic [127:0]       rk_sel;
  logic               last;
  logic [127:0]       round_out;

  round_key11 #(.NR(NR)) u_round_key11 (
    .key_i (key_q),
    .rk_o  (rk)
  );

  // FINAL leaves cnt at 1, so k0 is selected by state rather than by cnt.
  assign last   = (state_q == FINAL);
  assign rk_sel = last ? rk[0] : rk[cnt_q];

  inv_round u_inv_round (
    .st_i      (st_q),
    .rk_i      (rk_sel),
    .last_i    (last),
    .next_st_o (round_out)
  );

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    st_d        = st_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          key_d   = key_in;
          st_d    = data_in;
          state_d = INIT;
        end
      end
      INIT: begin
        st_d    = st_q ^ rk[NR];
        cnt_d   = 4'(NR - 1);
        state_d = ROUND;
      end
      ROUND: begin
        st_d = round_out;
        if (cnt_q == 4'd1) state_d = FINAL;
        else               cnt_d   = cnt_q - 4'd1;
      end
      FINAL: begin
        out_data_d  = round_out;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (CLR_OUT) out_data_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      key_q       <= '0;
      st_q        <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_decryption_seq.sv
// Scoreboarded bench for decryption_seq: FIPS-197 vectors, backpressure,
// mid-run reset, edge data and back-to-back random round trips.
module tb_decryption_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic [127:0] key_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic         in_ready_h, out_valid_h, busy_h;
  logic [127:0] out_data_h;

  always #5 clk = ~clk;

  decryption_seq #(.NR(10), .CLR_OUT(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .key_in(key_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  decryption_seq #(.NR(10), .CLR_OUT(1'b0)) u_hold (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_h),
    .data_in(data_in), .key_in(key_in), .out_valid(out_valid_h),
    .out_ready(out_ready), .out_data(out_data_h), .busy(busy_h)
  );

  int unsigned  n_checks = 0, n_pass = 0, n_fail = 0;
  int           cyc = 0, acc_cyc = 0, cons_cyc = 0, n_acc = 0;
  bit           have_cons = 0, b2b = 0, ov_prev = 0;
  logic [127:0] sbq[$];
  logic [127:0] cur_exp;
  logic [7:0]   sb [256];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box rebuilt from its definition: GF inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sb[w3[23:16]] ^ rc, sb[w3[15:8]], sb[w3[7:0]], sb[w3[31:24]]};
    w0 ^= t; w1 ^= w0; w2 ^= w1; w3 ^= w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s, t, k;
    logic [7:0]   rc, a0, a1, a2, a3;
    s  = pt ^ key;
    k  = key;
    rc = 8'h01;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      k  = next_key(k, rc);
      rc = gm(rc, 8'h02);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[127 - 8*(4*c + r) -: 8] = sb[s[127 - 8*(4*((c + r) % 4) + r) -: 8]];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          {a0, a1, a2, a3} = t[127 - 32*c -: 32];
          t[127 - 32*c -: 32] = {gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3,
                                 a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3,
                                 a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3),
                                 gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2)};
        end
      end
      s = t ^ k;
    end
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: score handshakes seen before the edge, then check timing after it.
  task automatic tick();
    bit acc, cons;
    logic [127:0] e;
    acc  = in_valid && in_ready && !rst;
    cons = out_valid && out_ready && !rst;
    if (cons) begin
      if (sbq.size() == 0) chk("unexpected_output", out_data, 128'hx);
      else begin
        e = sbq.pop_front();
        chk("sb_data", out_data, e);
        chk("sb_data_hold_dut", out_data_h, e);
      end
    end
    if (acc) sbq.push_back(cur_exp);
    @(posedge clk);
    cyc++;
    if (acc) begin acc_cyc = cyc; n_acc++; end
    if (cons) begin cons_cyc = cyc; have_cons = 1; end
    if (rst) begin sbq.delete(); have_cons = 0; end
    #1;
    if (out_valid && !ov_prev) begin
      chk("latency", 128'(cyc - acc_cyc), 128'd11);
      if (b2b && have_cons) chk("period", 128'(cyc - cons_cyc), 128'd12);
    end
    ov_prev = out_valid;
  endtask

  task automatic accept_block(input logic [127:0] d, input logic [127:0] k, input logic [127:0] e);
    int a0, n;
    data_in = d; key_in = k; cur_exp = e; in_valid = 1'b1;
    a0 = n_acc; n = 0;
    while (n_acc == a0 && n < 40) begin tick(); n++; end
    chk("accept_timeout", 128'(n_acc != a0), 128'd1);
  endtask

  task automatic wait_ov(input int bound);
    int n = 0;
    while (!out_valid && n < bound) begin tick(); n++; end
    chk("out_valid_timeout", 128'(out_valid), 128'd1);
  endtask

  task automatic run_block(input logic [127:0] d, input logic [127:0] k, input logic [127:0] e);
    accept_block(d, k, e);
    in_valid = 1'b0;
    data_in  = rnd128();
    key_in   = rnd128();
    chk("busy_after_accept", 128'(busy), 128'd1);
    wait_ov(20);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("clr_out_after_consume", out_data, '0);
    chk("hold_out_after_consume", out_data_h, e);
    chk("in_ready_after_consume", 128'(in_ready), 128'd1);
  endtask

  initial begin
    logic [127:0] pt, key, held;
    int a_before;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_in = '0; key_in = '0; cur_exp = '0;
    build_sbox();
    tick(); tick();
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", out_data, '0);
    rst = 1'b0;

    run_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h000102030405060708090a0b0c0d0e0f,
              128'h00112233445566778899aabbccddeeff);
    run_block(128'h3925841d02dc09fbdc118597196a0b32, 128'h2b7e151628aed2a6abf7158809cf4f3c,
              128'h3243f6a8885a308d313198a2e0370734);

    // Backpressure: result held while a second block waits at the input.
    accept_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h000102030405060708090a0b0c0d0e0f,
                 128'h00112233445566778899aabbccddeeff);
    in_valid = 1'b0;
    wait_ov(20);
    held = 128'h00112233445566778899aabbccddeeff;
    data_in = 128'h3925841d02dc09fbdc118597196a0b32; key_in = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    cur_exp = 128'h3243f6a8885a308d313198a2e0370734; in_valid = 1'b1;
    a_before = n_acc;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      chk("bp_out_data", out_data, held);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
    end
    chk("bp_no_accept", 128'(n_acc - a_before), 128'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    chk("bp_accept_after_consume", 128'(n_acc - a_before), 128'd1);
    in_valid = 1'b0;
    wait_ov(20);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset during ROUND with cnt=5 aborts without output.
    accept_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h000102030405060708090a0b0c0d0e0f,
                 128'h00112233445566778899aabbccddeeff);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_busy", 128'(busy), 128'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
    chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_out_data", out_data, '0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("mid_rst_no_output", 128'(out_valid), 128'd0);
    end
    run_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h000102030405060708090a0b0c0d0e0f,
              128'h00112233445566778899aabbccddeeff);

    // Edge data.
    run_block(128'h66e94bd4ef8a2c3b884cfa59ca342b2e, '0, '0);
    run_block(aes_enc('0, '0), '0, '0);
    run_block(aes_enc('1, '1), '1, '1);
    run_block(aes_enc('0, '1), '1, '0);
    run_block(aes_enc('1, '0), '0, '1);

    // Back-to-back random round trips with the consumer always ready.
    b2b = 1; have_cons = 0; out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      pt  = rnd128();
      key = rnd128();
      accept_block(aes_enc(pt, key), key, pt);
    end
    in_valid = 1'b0;
    for (int n = 0; n < 40 && sbq.size() != 0; n++) tick();
    chk("drain_empty", 128'(sbq.size()), 128'd0);
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
